// File: rtl/rom_stream_rd_pkg.sv
// Shared types for the ROM streaming read initiator: FSM state encoding and buffer depth.
package rom_stream_rd_pkg;

  typedef enum logic [1:0] {
    ROM_RD_IDLE  = 2'd0,
    ROM_RD_READ  = 2'd1,
    ROM_RD_DRAIN = 2'd2
  } rom_rd_state_e;

  localparam int RomRdBufDepth = 2;

endpackage

// File: rtl/rom_rd_fifo2.sv
// Two-entry data buffer that absorbs ROM read latency and consumer backpressure.
module rom_rd_fifo2
  import rom_stream_rd_pkg::*;
#(
  parameter int Word_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [Word_Width-1:0] din_i,
  output logic [Word_Width-1:0] dout_o,
  output logic [1:0]            occ_o
);

  logic [Word_Width-1:0] mem_q [RomRdBufDepth];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;

  // Push and pop in the same cycle leave the occupancy unchanged.
  always_comb begin
    occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/rom_stream_rd.sv
// Burst read initiator for a 1-cycle registered-read ROM, streaming words over valid/ready.
// Optional feature: define ROM_RD_PROT_EN to reject bursts that run past the top of the ROM.
module rom_stream_rd
  import rom_stream_rd_pkg::*;
#(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Addr_Width:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rom_cen_o,
  output logic                  rom_oen_o,
  output logic [Addr_Width-1:0] rom_addr_o,
  input  logic [Word_Width-1:0] rom_data_i,
  output logic [Word_Width-1:0] dat_o,
  output logic                  val_o,
  input  logic                  rdy_i
);

  rom_rd_state_e         state_q, state_d;
  logic [Addr_Width-1:0] addr_q, addr_d;
  logic [Addr_Width:0]   rem_q, rem_d;
  logic                  infl_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  issue;
  logic                  drain_done;
  logic                  reject;
  logic                  room;
  logic                  pop;
  logic [1:0]            occ;

`ifdef ROM_RD_PROT_EN
  assign reject = (32'(addr_i) + 32'(len_i)) > (32'd1 << Addr_Width);
`else
  assign reject = 1'b0;
`endif

  assign val_o  = (occ != 2'd0);
  assign pop    = val_o & rdy_i;
  assign busy_o = (state_q != ROM_RD_IDLE);
  // A new read may go out only if its word is guaranteed a buffer slot when it lands.
  assign room   = ({1'b0, occ} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});

  // The first read is issued in the accepting cycle so data arrives two cycles after start.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    rom_addr_o = addr_q;
    case (state_q)
      ROM_RD_IDLE: begin
        if (start_i) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            rom_addr_o = addr_i;
            addr_d     = addr_i + 1'b1;
            rem_d      = len_i - 1'b1;
            state_d    = (len_i == (Addr_Width+1)'(1)) ? ROM_RD_DRAIN : ROM_RD_READ;
          end
        end
      end
      ROM_RD_READ: begin
        if (room) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (Addr_Width+1)'(1)) begin
            state_d = ROM_RD_DRAIN;
          end
        end
      end
      ROM_RD_DRAIN: begin
        if ((occ == 2'd0) && !infl_q) begin
          drain_done = 1'b1;
          state_d    = ROM_RD_IDLE;
        end
      end
      default: state_d = ROM_RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ROM_RD_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      infl_q  <= issue;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_cen_o = ~issue;
  assign rom_oen_o = ~(busy_o | infl_q);
  assign done_o    = drain_done | done_q;
  assign err_o     = err_q;

  // Every read issued last cycle returns now, so capture is unconditional.
  rom_rd_fifo2 #(
    .Word_Width(Word_Width)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push_i(infl_q),
    .pop_i (pop),
    .din_i (rom_data_i),
    .dout_o(dat_o),
    .occ_o (occ)
  );

endmodule

// File: tb/tb_rom_stream_rd.sv
// Directed bench for rom_stream_rd with a registered-read ROM model where ROM[i] = i.
module tb_rom_stream_rd;

  localparam int WW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] addr_i;
  logic [AW:0]   len_i;
  logic          busy_o, done_o, err_o, rom_cen_o, rom_oen_o;
  logic [AW-1:0] rom_addr_o;
  logic [WW-1:0] rom_data_i, dat_o, rom_q;
  logic          val_o, rdy_i;

  int errors = 0;
  int checks = 0;

  // Results of the most recent drive_burst call.
  logic [WW-1:0] words[$];
  logic [AW-1:0] issued[$];
  int first_val, last_pop, done_cyc, done_cnt, unstable, overissue, oen_bad, err_cnt;
  bit timed_out;
  logic busy_after, cen_after;
  logic [AW-1:0] addr_after;

  always #5 clk = ~clk;

  // ROM model: registered read on cen, data driven only while oen is low.
  always_ff @(posedge clk) begin
    if (!rom_cen_o) rom_q <= WW'(rom_addr_o);
  end
  assign rom_data_i = rom_oen_o ? 32'hDEAD_BEEF : rom_q;

  rom_stream_rd #(.Word_Width(WW), .Addr_Width(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rom_cen_o(rom_cen_o), .rom_oen_o(rom_oen_o), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .dat_o(dat_o), .val_o(val_o), .rdy_i(rdy_i)
  );

  // Runs one burst from posedge+1 until the cycle after done_o, recording observations only.
  task automatic drive_burst(input logic [AW-1:0] a, input logic [AW:0] l,
                             input int mode, input bit hold, input int budget);
    int outstanding = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic prev_issue = 1'b0;
    logic [WW-1:0] prev_dat = '0;
    logic pop;
    words.delete(); issued.delete();
    first_val = -1; last_pop = -1; done_cyc = -1; done_cnt = 0;
    unstable = 0; overissue = 0; oen_bad = 0; err_cnt = 0; timed_out = 0;
    busy_after = 1'b1; cen_after = 1'b1; addr_after = '0;
    start_i = 1'b1; addr_i = a; len_i = l;
    forever begin
      rdy_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy_o; cen_after = rom_cen_o; addr_after = rom_addr_o;
        break;
      end
      pop = val_o & rdy_i;
      if (prev_stall && (!val_o || dat_o !== prev_dat)) unstable++;
      if (prev_issue && rom_oen_o !== 1'b0) oen_bad++;
      if (!rom_cen_o && (outstanding - (pop ? 1 : 0)) >= 2) overissue++;
      if (!rom_cen_o) issued.push_back(rom_addr_o);
      if (pop) begin
        words.push_back(dat_o);
        if (first_val < 0) first_val = cyc;
        last_pop = cyc;
      end
      if (err_o) err_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      outstanding += (!rom_cen_o ? 1 : 0) - (pop ? 1 : 0);
      prev_stall = val_o && !rdy_i;
      prev_dat   = dat_o;
      prev_issue = !rom_cen_o;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (!hold) start_i = 1'b0;
      cyc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; addr_i = '0; len_i = '0; rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    checks++; if ({rom_cen_o, rom_oen_o} !== 2'b11) begin errors++; $display("[TB] FAIL reset_cen_oen: got %b expected 11", {rom_cen_o, rom_oen_o}); end
    checks++; if (rom_addr_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", rom_addr_o); end
    checks++; if ({val_o, dat_o} !== 33'h0) begin errors++; $display("[TB] FAIL reset_stream: got %b/%h expected 0/0", val_o, dat_o); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_stream();
    drive_burst(8'h10, 9'd4, 0, 1'b0, 40);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected done"); end
    checks++; if (words.size() !== 4) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 4", words.size()); end
    for (int k = 0; k < words.size(); k++) begin
      checks++; if (words[k] !== WW'(8'h10 + k)) begin errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h", k, words[k], 8'h10 + k); end
    end
    checks++; if (first_val !== 2) begin errors++; $display("[TB] FAIL basic_first_val: got %0d expected 2", first_val); end
    checks++; if (last_pop !== 5) begin errors++; $display("[TB] FAIL basic_last_pop: got %0d expected 5", last_pop); end
    checks++; if (done_cyc !== 6 || done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done: got cyc %0d cnt %0d expected cyc 6 cnt 1", done_cyc, done_cnt); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy_after); end
    checks++; if (oen_bad !== 0 || err_cnt !== 0) begin errors++; $display("[TB] FAIL basic_oen_err: got %0d/%0d expected 0/0", oen_bad, err_cnt); end
  endtask

  task automatic test_backpressure();
    drive_burst(8'h00, 9'd6, 1, 1'b0, 80);
    checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("[TB] FAIL bp_done: got timeout %b cnt %0d expected 0/1", timed_out, done_cnt); end
    checks++; if (words.size() !== 6) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 6", words.size()); end
    for (int k = 0; k < words.size(); k++) begin
      checks++; if (words[k] !== WW'(k)) begin errors++; $display("[TB] FAIL bp_word%0d: got %h expected %h", k, words[k], k); end
    end
    checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++; if (overissue !== 0) begin errors++; $display("[TB] FAIL bp_overissue: got %0d expected 0", overissue); end
    checks++; if (issued.size() !== 6) begin errors++; $display("[TB] FAIL bp_issues: got %0d expected 6", issued.size()); end
  endtask

  task automatic test_wrap();
`ifdef ROM_RD_PROT_EN
    int cen_low = 0;
    int dones = 0;
    start_i = 1'b1; addr_i = 8'hFE; len_i = 9'd4; rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (rom_cen_o !== 1'b1) begin errors++; $display("[TB] FAIL prot_cen0: got %b expected 1", rom_cen_o); end
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL prot_err: got err %b busy %b expected 1/0", err_o, busy_o); end
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!rom_cen_o) cen_low++;
      if (done_o || err_o) dones++;
    end
    checks++; if (cen_low !== 0 || dones !== 0) begin errors++; $display("[TB] FAIL prot_quiet: got cen %0d pulses %0d expected 0/0", cen_low, dones); end
    @(posedge clk); #1;
`else
    logic [AW-1:0] exp_a;
    drive_burst(8'hFE, 9'd4, 0, 1'b0, 40);
    checks++; if (timed_out || done_cnt !== 1) begin errors++; $display("[TB] FAIL wrap_done: got timeout %b cnt %0d expected 0/1", timed_out, done_cnt); end
    checks++; if (issued.size() !== 4 || words.size() !== 4) begin errors++; $display("[TB] FAIL wrap_count: got %0d/%0d expected 4/4", issued.size(), words.size()); end
    for (int k = 0; k < 4 && k < words.size() && k < issued.size(); k++) begin
      exp_a = AW'(8'hFE + k);
      checks++; if (issued[k] !== exp_a || words[k] !== WW'(exp_a)) begin errors++; $display("[TB] FAIL wrap_%0d: got addr %h data %h expected %h", k, issued[k], words[k], exp_a); end
    end
`endif
  endtask

  task automatic test_length_bounds();
    start_i = 1'b1; addr_i = 8'h40; len_i = 9'd0; rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (rom_cen_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("[TB] FAIL len0_c0: got cen %b busy %b done %b expected 1/0/0", rom_cen_o, busy_o, done_o); end
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || rom_cen_o !== 1'b1) begin errors++; $display("[TB] FAIL len0_c1: got done %b busy %b cen %b expected 1/0/1", done_o, busy_o, rom_cen_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL len0_c2: got done %b busy %b expected 0/0", done_o, busy_o); end
    @(posedge clk); #1;
    drive_burst(8'h00, 9'd256, 0, 1'b0, 400);
    checks++; if (timed_out || done_cyc !== 258) begin errors++; $display("[TB] FAIL len256_done: got timeout %b cyc %0d expected 0/258", timed_out, done_cyc); end
    checks++; if (words.size() !== 256) begin errors++; $display("[TB] FAIL len256_count: got %0d expected 256", words.size()); end
    for (int k = 0; k < words.size(); k++) begin
      checks++; if (words[k] !== WW'(k)) begin errors++; $display("[TB] FAIL len256_word%0d: got %h expected %h", k, words[k], k); end
    end
  endtask

  task automatic test_reset_mid_burst();
    start_i = 1'b1; addr_i = 8'h20; len_i = 9'd8; rdy_i = 1'b0;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || busy_o !== 1'b1 || dat_o !== 32'h20) begin errors++; $display("[TB] FAIL mid_pre: got val %b busy %b dat %h expected 1/1/20", val_o, busy_o, dat_o); end
    rst = 1'b1;
    #1;
    checks++; if ({busy_o, done_o, err_o, val_o} !== 4'b0000) begin errors++; $display("[TB] FAIL mid_flags: got %b expected 0000", {busy_o, done_o, err_o, val_o}); end
    checks++; if ({rom_cen_o, rom_oen_o} !== 2'b11 || rom_addr_o !== 8'h00 || dat_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_rom: got %b %h %h expected 11 00 0", {rom_cen_o, rom_oen_o}, rom_addr_o, dat_o); end
    @(posedge clk); #1; rst = 1'b0; rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || val_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_post: got done %b val %b expected 0/0", done_o, val_o); end
    @(posedge clk); #1;
    drive_burst(8'h30, 9'd3, 0, 1'b0, 40);
    checks++; if (timed_out || done_cnt !== 1 || first_val !== 2) begin errors++; $display("[TB] FAIL mid_fresh: got timeout %b done %0d first %0d expected 0/1/2", timed_out, done_cnt, first_val); end
    checks++; if (words.size() !== 3) begin errors++; $display("[TB] FAIL mid_fresh_count: got %0d expected 3", words.size()); end
    for (int k = 0; k < words.size(); k++) begin
      checks++; if (words[k] !== WW'(8'h30 + k)) begin errors++; $display("[TB] FAIL mid_fresh_word%0d: got %h expected %h", k, words[k], 8'h30 + k); end
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    bit seen = 0;
    drive_burst(8'h50, 9'd3, 0, 1'b1, 40);
    checks++; if (timed_out || done_cnt !== 1 || issued.size() !== 3) begin errors++; $display("[TB] FAIL b2b_first: got timeout %b done %0d issues %0d expected 0/1/3", timed_out, done_cnt, issued.size()); end
    checks++; if (busy_after !== 1'b0 || cen_after !== 1'b0 || addr_after !== 8'h50) begin errors++; $display("[TB] FAIL b2b_accept: got busy %b cen %b addr %h expected 0/0/50", busy_after, cen_after, addr_after); end
    start_i = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      if (done_o) seen = 1;
      @(posedge clk); #1;
      waited++;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_second_done: got no done expected done within 20 cycles"); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_wrap();
    test_length_bounds();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
